// File: rtl/cell_comm_packet_decoder.sv
// Fast-orbit packet parser for the cell-controller Aurora RX stream.
// Emits one strobe per good packet and keeps error and per-FA-cycle tallies.
module cell_comm_packet_decoder #(
    parameter int DATA_WIDTH      = 32,
    parameter int FOFB_IDX_WIDTH  = 9,
    parameter int WATCHDOG_CYCLES = 63
) (
    input  logic                      rxClk,
    input  logic                      rxReset,
    input  logic                      rxValid,
    input  logic                      rxLast,
    input  logic [DATA_WIDTH-1:0]     rxData,
    input  logic                      rxFaStrobe,
    output logic                      outValid,
    output logic [FOFB_IDX_WIDTH-1:0] outIndex,
    output logic [31:0]               outX,
    output logic [31:0]               outY,
    output logic [31:0]               outS,
    output logic                      outClipping,
    output logic [15:0]               cyclePacketCount,
    output logic [15:0]               badHeaderCount,
    output logic [15:0]               shortPacketCount,
    output logic [15:0]               longPacketCount,
    output logic [15:0]               invalidFlagCount,
    output logic [15:0]               watchdogCount
);

    localparam logic [2:0] S_HEADER  = 3'd0;
    localparam logic [2:0] S_WX      = 3'd1;
    localparam logic [2:0] S_WY      = 3'd2;
    localparam logic [2:0] S_WS      = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;

    localparam logic [7:0]  WD_LAST = 8'(WATCHDOG_CYCLES - 1);
    localparam logic [15:0] MAGIC   = 16'hA5BE;

    logic [2:0]                state_q, state_d;
    logic [7:0]                wd_q, wd_d;
    logic [FOFB_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]               x_q, x_d;
    logic [31:0]               y_q, y_d;

    logic                      hdr_ok;
    logic                      good;
    logic                      bad_inc;
    logic                      short_inc;
    logic                      long_inc;
    logic                      inv_inc;
    logic                      wd_inc;

    logic                      out_valid_q;
    logic [FOFB_IDX_WIDTH-1:0] out_idx_q;
    logic [31:0]               out_x_q;
    logic [31:0]               out_y_q;
    logic [31:0]               out_s_q;
    logic                      out_clip_q;

    logic [15:0]               run_q;
    logic [15:0]               cyc_q;
    logic [15:0]               bad_q;
    logic [15:0]               short_q;
    logic [15:0]               long_q;
    logic [15:0]               inv_q;
    logic [15:0]               wdc_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A header carrying rxLast can never start a packet, so it is bad.
    assign hdr_ok = (rxData[31:16] == MAGIC)
                 && (rxData[15:FOFB_IDX_WIDTH] == '0)
                 && !rxLast;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        good      = 1'b0;
        bad_inc   = 1'b0;
        short_inc = 1'b0;
        long_inc  = 1'b0;
        inv_inc   = 1'b0;
        wd_inc    = 1'b0;
        if (rxValid) begin
            wd_d = '0;
            unique case (state_q)
                S_HEADER: begin
                    if (hdr_ok) begin
                        idx_d   = rxData[FOFB_IDX_WIDTH-1:0];
                        state_d = S_WX;
                    end else begin
                        bad_inc = 1'b1;
                        state_d = rxLast ? S_HEADER : S_DISCARD;
                    end
                end
                S_WX: begin
                    if (rxLast) begin
                        short_inc = 1'b1;
                        state_d   = S_HEADER;
                    end else begin
                        x_d     = rxData[31:0];
                        state_d = S_WY;
                    end
                end
                S_WY: begin
                    if (rxLast) begin
                        short_inc = 1'b1;
                        state_d   = S_HEADER;
                    end else begin
                        y_d     = rxData[31:0];
                        state_d = S_WS;
                    end
                end
                S_WS: begin
                    if (!rxLast) begin
                        long_inc = 1'b1;
                        state_d  = S_DISCARD;
                    end else if (rxData[31]) begin
                        inv_inc = 1'b1;
                        state_d = S_HEADER;
                    end else begin
                        good    = 1'b1;
                        state_d = S_HEADER;
                    end
                end
                S_DISCARD: begin
                    if (rxLast) state_d = S_HEADER;
                end
                default: state_d = S_HEADER;
            endcase
        end else if (state_q != S_HEADER) begin
            if (wd_q == WD_LAST) begin
                wd_inc  = 1'b1;
                wd_d    = '0;
                state_d = S_HEADER;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end else begin
            wd_d = '0;
        end
    end

    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            state_q <= S_HEADER;
            wd_q    <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_s_q     <= '0;
            out_clip_q  <= 1'b0;
        end else begin
            out_valid_q <= good;
            if (good) begin
                out_idx_q  <= idx_q;
                out_x_q    <= x_q;
                out_y_q    <= y_q;
                out_s_q    <= {{2{rxData[29]}}, rxData[29:0]};
                out_clip_q <= rxData[30];
            end
        end
    end

    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            bad_q   <= '0;
            short_q <= '0;
            long_q  <= '0;
            inv_q   <= '0;
            wdc_q   <= '0;
        end else begin
            if (bad_inc)   bad_q   <= sat_inc(bad_q);
            if (short_inc) short_q <= sat_inc(short_q);
            if (long_inc)  long_q  <= sat_inc(long_q);
            if (inv_inc)   inv_q   <= sat_inc(inv_q);
            if (wd_inc)    wdc_q   <= sat_inc(wdc_q);
        end
    end

    // A strobe coinciding with the FA marker belongs to the new cycle.
    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            run_q <= '0;
            cyc_q <= '0;
        end else if (rxFaStrobe) begin
            cyc_q <= run_q;
            run_q <= {15'd0, out_valid_q};
        end else if (out_valid_q) begin
            run_q <= sat_inc(run_q);
        end
    end

    assign outValid         = out_valid_q;
    assign outIndex         = out_idx_q;
    assign outX             = out_x_q;
    assign outY             = out_y_q;
    assign outS             = out_s_q;
    assign outClipping      = out_clip_q;
    assign cyclePacketCount = cyc_q;
    assign badHeaderCount   = bad_q;
    assign shortPacketCount = short_q;
    assign longPacketCount  = long_q;
    assign invalidFlagCount = inv_q;
    assign watchdogCount    = wdc_q;

endmodule

// File: tb/tb_cell_comm_packet_decoder.sv
// Bench for cell_comm_packet_decoder: directed cases plus random packets
// scored against a per-packet classification model.
module tb_cell_comm_packet_decoder;

    localparam int WD = 63;

    logic        clk = 1'b0;
    logic        rxReset;
    logic        rxValid;
    logic        rxLast;
    logic [31:0] rxData;
    logic        rxFaStrobe;
    logic        outValid;
    logic [8:0]  outIndex;
    logic [31:0] outX;
    logic [31:0] outY;
    logic [31:0] outS;
    logic        outClipping;
    logic [15:0] cyclePacketCount;
    logic [15:0] badHeaderCount;
    logic [15:0] shortPacketCount;
    logic [15:0] longPacketCount;
    logic [15:0] invalidFlagCount;
    logic [15:0] watchdogCount;

    always #5 clk = ~clk;

    cell_comm_packet_decoder #(
        .DATA_WIDTH     (32),
        .FOFB_IDX_WIDTH (9),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .rxClk           (clk),
        .rxReset         (rxReset),
        .rxValid         (rxValid),
        .rxLast          (rxLast),
        .rxData          (rxData),
        .rxFaStrobe      (rxFaStrobe),
        .outValid        (outValid),
        .outIndex        (outIndex),
        .outX            (outX),
        .outY            (outY),
        .outS            (outS),
        .outClipping     (outClipping),
        .cyclePacketCount(cyclePacketCount),
        .badHeaderCount  (badHeaderCount),
        .shortPacketCount(shortPacketCount),
        .longPacketCount (longPacketCount),
        .invalidFlagCount(invalidFlagCount),
        .watchdogCount   (watchdogCount)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] m_bad, m_short, m_long, m_inv, m_wd;
    logic [15:0] m_run, m_cyc;
    bit          prev_good;
    bit          fa_rand;
    logic [8:0]  e_idx;
    logic [31:0] e_x, e_y, e_s;
    logic        e_clip;
    logic [31:0] pkt[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_chk++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, want);
    endtask

    function automatic logic [15:0] sinc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic tick(input bit v, input bit l, input logic [31:0] d,
                        input bit gl, input bit fa);
        rxValid    = v;
        rxLast     = l;
        rxData     = d;
        rxFaStrobe = fa || (fa_rand && $urandom_range(0, 15) == 0);
        @(posedge clk);
        if (rxFaStrobe) begin
            m_cyc = m_run;
            m_run = prev_good ? 16'd1 : 16'd0;
        end else if (prev_good) begin
            m_run = sinc(m_run);
        end
        prev_good = gl;
        #1;
        chk("outValid", 32'(outValid), 32'(gl));
        if (gl) begin
            chk("outIndex", 32'(outIndex), 32'(e_idx));
            chk("outX", outX, e_x);
            chk("outY", outY, e_y);
            chk("outS", outS, e_s);
            chk("outClip", 32'(outClipping), 32'(e_clip));
        end
        chk("cyclePkt", 32'(cyclePacketCount), 32'(m_cyc));
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, $urandom, 1'b0, 1'b0);
    endtask

    task automatic check_counters();
        chk("badHdr", 32'(badHeaderCount), 32'(m_bad));
        chk("short", 32'(shortPacketCount), 32'(m_short));
        chk("long", 32'(longPacketCount), 32'(m_long));
        chk("invFlag", 32'(invalidFlagCount), 32'(m_inv));
        chk("watchdog", 32'(watchdogCount), 32'(m_wd));
    endtask

    task automatic do_reset();
        rxReset    = 1'b1;
        rxValid    = 1'($urandom_range(0, 1));
        rxLast     = 1'b0;
        rxData     = $urandom;
        rxFaStrobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rxReset   = 1'b0;
        rxValid   = 1'b0;
        m_bad     = '0;
        m_short   = '0;
        m_long    = '0;
        m_inv     = '0;
        m_wd      = '0;
        m_run     = '0;
        m_cyc     = '0;
        prev_good = 1'b0;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_outIndex", 32'(outIndex), 32'd0);
        chk("rst_outX", outX, 32'd0);
        chk("rst_outY", outY, 32'd0);
        chk("rst_outS", outS, 32'd0);
        chk("rst_outClip", 32'(outClipping), 32'd0);
        chk("rst_cyclePkt", 32'(cyclePacketCount), 32'd0);
        check_counters();
    endtask

    // Classify the whole packet from its content, then drive it.
    // k: stall after word k (-1 = none), g: stall length in idle cycles.
    task automatic send(input int k, input int g, input bit fa_after);
        int          len;
        int          sent;
        bit          to;
        bit          hgood;
        bit          good;
        logic [31:0] h;
        logic [31:0] w3;
        len   = pkt.size();
        to    = (k >= 0) && (g >= WD);
        sent  = to ? k + 1 : len;
        h     = pkt[0];
        hgood = (h[31:16] == 16'hA5BE) && (h[15:9] == 7'd0) && (len > 1);
        good  = 1'b0;
        if (!hgood) begin
            m_bad = sinc(m_bad);
            if (to) m_wd = sinc(m_wd);
        end else if (!to) begin
            if (len < 4) m_short = sinc(m_short);
            else if (len > 4) m_long = sinc(m_long);
            else begin
                w3 = pkt[3];
                if (w3[31]) m_inv = sinc(m_inv);
                else good = 1'b1;
            end
        end else begin
            if (k >= 3) m_long = sinc(m_long);
            m_wd = sinc(m_wd);
        end
        if (good) begin
            w3     = pkt[3];
            e_idx  = h[8:0];
            e_x    = pkt[1];
            e_y    = pkt[2];
            e_s    = {{2{w3[29]}}, w3[29:0]};
            e_clip = w3[30];
        end
        for (int i = 0; i < sent; i++) begin
            tick(1'b1, i == len - 1, pkt[i], good && (i == len - 1), 1'b0);
            if (i == k) idle(g);
        end
        tick(1'b0, 1'b0, $urandom, 1'b0, fa_after);
        idle($urandom_range(0, 3));
        check_counters();
    endtask

    task automatic good_pkt(input int k, input int g, input bit fa_after);
        pkt.delete();
        pkt.push_back({16'hA5BE, 7'd0, 9'($urandom)});
        pkt.push_back($urandom);
        pkt.push_back($urandom);
        pkt.push_back({1'b0, 31'($urandom)});
        send(k, g, fa_after);
    endtask

    task automatic rand_packet();
        int          r;
        int          len;
        int          k;
        int          g;
        logic [31:0] h;
        logic [31:0] w;
        r   = $urandom_range(0, 9);
        len = (r == 5) ? $urandom_range(1, 3)
            : (r == 6) ? $urandom_range(5, 7) : 4;
        case ($urandom_range(0, 9))
            0:       h = $urandom;
            1:       h = {16'hA5BE, 7'($urandom_range(1, 127)), 9'($urandom)};
            default: h = {16'hA5BE, 7'd0, 9'($urandom)};
        endcase
        pkt.delete();
        pkt.push_back(h);
        for (int i = 1; i < len; i++) begin
            w = $urandom;
            if (i == 3) w[31] = ($urandom_range(0, 4) == 0);
            pkt.push_back(w);
        end
        k = -1;
        g = 0;
        if (len > 1 && $urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, len - 2);
            case ($urandom_range(0, 5))
                0:       g = 1;
                1:       g = 20;
                2:       g = WD - 1;
                3:       g = WD;
                4:       g = WD + 1;
                default: g = 90;
            endcase
        end
        send(k, g, 1'b0);
    endtask

    initial begin
        fa_rand = 1'b0;
        do_reset();

        pkt = '{32'hA5BE0023, 32'h00001111, 32'hFFFFEEEE, 32'h60000005};
        send(-1, 0, 1'b0);
        chk("t1_index", 32'(outIndex), 32'h23);
        chk("t1_x", outX, 32'h00001111);
        chk("t1_y", outY, 32'hFFFFEEEE);
        chk("t1_s", outS, 32'hE0000005);
        chk("t1_clip", 32'(outClipping), 32'd1);

        pkt = '{32'h12340023, 32'h1, 32'h2, 32'h3};
        send(-1, 0, 1'b0);
        chk("t2_bad", 32'(badHeaderCount), 32'd1);
        good_pkt(-1, 0, 1'b0);

        pkt = '{32'hA5BE0007, 32'h11, 32'h22};
        send(-1, 0, 1'b0);
        chk("t3_short", 32'(shortPacketCount), 32'd1);
        good_pkt(-1, 0, 1'b0);

        pkt = '{32'hA5BE0001, 32'h1, 32'h2, 32'h80000001};
        send(-1, 0, 1'b0);
        chk("t4_inv", 32'(invalidFlagCount), 32'd1);
        pkt = '{32'hA5BE0002, 32'h1, 32'h2, 32'h3, 32'h4};
        send(-1, 0, 1'b0);
        chk("t4_long", 32'(longPacketCount), 32'd1);

        good_pkt(1, WD, 1'b0);
        chk("t5_wd63", 32'(watchdogCount), 32'd1);
        pkt = '{32'hA5BE0055, 32'hCAFE0001, 32'h2, 32'h3};
        send(1, WD - 1, 1'b0);
        chk("t5_wd62", 32'(watchdogCount), 32'd1);
        chk("t5_x", outX, 32'hCAFE0001);

        do_reset();
        repeat (3) good_pkt(-1, 0, 1'b0);
        good_pkt(-1, 0, 1'b1);
        chk("t6_faCyc", 32'(cyclePacketCount), 32'd3);
        tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("t6_faRun", 32'(cyclePacketCount), 32'd1);

        tick(1'b1, 1'b0, 32'hA5BE0011, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 32'h1234, 1'b0, 1'b0);
        do_reset();
        idle(3);
        good_pkt(-1, 0, 1'b0);

        fa_rand = 1'b1;
        repeat (300) rand_packet();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
